// File: rtl/flex_counter_pkg.sv
// Shared types and defaults for the flex counter family.
package flex_counter_pkg;

    localparam int unsigned DEFAULT_CNT_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/flex_down_counter.sv
// Loadable down-counter/timer with one-cycle done pulse and sticky zero flag.
// Define FLEX_DOWN_COUNTER_RELOAD_EN for periodic auto-reload on expiry.
module flex_down_counter
    import flex_counter_pkg::*;
#(
    parameter int unsigned NUM_CNT_BITS = DEFAULT_CNT_BITS
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    busy,
    output logic                    zero_flag,
    output logic                    done_pulse
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = NUM_CNT_BITS'(0);
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

    state_t                  state_q, state_d;
    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    done_q,  done_d;

`ifdef FLEX_DOWN_COUNTER_RELOAD_EN
    logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
`endif

    // Next-state: clear beats load beats count_enable.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
`ifdef FLEX_DOWN_COUNTER_RELOAD_EN
        reload_d = reload_q;
`endif
        if (clear) begin
            state_d = IDLE;
            count_d = CNT_ZERO;
`ifdef FLEX_DOWN_COUNTER_RELOAD_EN
            reload_d = CNT_ZERO;
`endif
        end else if (load) begin
            count_d = load_val;
`ifdef FLEX_DOWN_COUNTER_RELOAD_EN
            reload_d = load_val;
`endif
            if (load_val != CNT_ZERO) begin
                state_d = RUN;
            end else begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end else if ((state_q == RUN) && count_enable) begin
            if (count_q > CNT_ONE) begin
                count_d = count_q - CNT_ONE;
            end else begin
`ifdef FLEX_DOWN_COUNTER_RELOAD_EN
                count_d = reload_q;
                done_d  = 1'b1;
`else
                count_d = CNT_ZERO;
                state_d = DONE;
                done_d  = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            count_q <= CNT_ZERO;
            done_q  <= 1'b0;
`ifdef FLEX_DOWN_COUNTER_RELOAD_EN
            reload_q <= CNT_ZERO;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
`ifdef FLEX_DOWN_COUNTER_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign count_out  = count_q;
    assign done_pulse = done_q;
    assign busy       = (state_q == RUN);
    assign zero_flag  = (state_q == DONE);

endmodule
